wb_retire_buffer: RTL and testbench

WB_RETIRE_BUFFER -- requirements
Module: wb_retire_buffer

---
 rtl/wb_retire_buffer.sv | 110 +++++++++++
 tb/tb_wb_retire_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_retire_buffer.sv
// Writeback retire buffer: circular FIFO between MEM and the register-file write port.
// Retires the head entry in order, raising exception/ERET flush pulses at retire time.
module wb_retire_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ms_to_ws_valid,
  output logic                     ws_allowin,
  input  logic [DATA_W-1:0]        ms_pc,
  input  logic [DATA_W-1:0]        ms_result,
  input  logic [4:0]               ms_dest,
  input  logic [3:0]               ms_rf_we,
  input  logic                     ms_ex,
  input  logic [4:0]               ms_excode,
  input  logic                     ms_eret,
  input  logic                     ms_mfc0,
  input  logic                     rf_ready,
  input  logic [DATA_W-1:0]        cp0_rdata,
  output logic [3:0]               rf_we,
  output logic [4:0]               rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [DATA_W-1:0]        debug_wb_pc,
  output logic [3:0]               debug_wb_rf_wen,
  output logic [4:0]               debug_wb_rf_wnum,
  output logic [DATA_W-1:0]        debug_wb_rf_wdata,
  output logic                     ws_ex,
  output logic [4:0]               ws_excode,
  output logic                     ws_eret,
  output logic                     ws_flush,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         retire_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] result;
    logic [4:0]        dest;
    logic [3:0]        rf_we;
    logic              ex;
    logic [4:0]        excode;
    logic              eret;
    logic              mfc0;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        hd;
  entry_t        wr;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push;
  logic          retire;

  assign hd = mem[head];
  assign wr = '{pc: ms_pc, result: ms_result, dest: ms_dest, rf_we: ms_rf_we,
                ex: ms_ex, excode: ms_excode, eret: ms_eret, mfc0: ms_mfc0};

  assign ws_allowin = (occupancy != FULL);
  // Reset wins over everything, so it also suppresses retire-time side effects.
  assign retire = (occupancy != '0) && rf_ready && !reset;
  assign push   = ms_to_ws_valid && ws_allowin && !ws_flush && !reset;

  always_comb begin
    rf_we     = (retire && !hd.ex) ? hd.rf_we : 4'b0;
    rf_waddr  = hd.dest;
    rf_wdata  = hd.mfc0 ? cp0_rdata : hd.result;
    ws_ex     = retire && hd.ex;
    ws_excode = ws_ex ? hd.excode : 5'd0;
    ws_eret   = retire && hd.eret && !hd.ex;
  end

  assign ws_flush          = ws_ex | ws_eret;
  assign debug_wb_pc       = hd.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      occupancy  <= '0;
      retire_cnt <= '0;
    end else begin
      // An ERET head is a committed instruction even though it flushes.
      if (retire && !hd.ex) retire_cnt <= retire_cnt + 1'b1;
      if (ws_flush) begin
        head      <= '0;
        tail      <= '0;
        occupancy <= '0;
      end else begin
        if (push)   tail <= tail + 1'b1;
        if (retire) head <= head + 1'b1;
        case ({push, retire})
          2'b10:   occupancy <= occupancy + 1'b1;
          2'b01:   occupancy <= occupancy - 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wb_retire_buffer.sv
// Directed bench for wb_retire_buffer: queue-based reference model checked every
// cycle, plus hand-computed literal checks for the fill/drain/stream/flush scenarios.
module tb_wb_retire_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ms_to_ws_valid = 1'b0;
  logic        ws_allowin;
  logic [31:0] ms_pc = '0, ms_result = '0;
  logic [4:0]  ms_dest = '0;
  logic [3:0]  ms_rf_we = '0;
  logic        ms_ex = 1'b0;
  logic [4:0]  ms_excode = '0;
  logic        ms_eret = 1'b0, ms_mfc0 = 1'b0;
  logic        rf_ready = 1'b0;
  logic [31:0] cp0_rdata = '0;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic        ws_ex, ws_eret, ws_flush;
  logic [4:0]  ws_excode;
  logic [2:0]  occupancy;
  logic [31:0] retire_cnt;

  always #5 clk = ~clk;

  wb_retire_buffer #(.DEPTH(DEPTH), .DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest), .ms_rf_we(ms_rf_we),
    .ms_ex(ms_ex), .ms_excode(ms_excode), .ms_eret(ms_eret), .ms_mfc0(ms_mfc0),
    .rf_ready(rf_ready), .cp0_rdata(cp0_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .ws_ex(ws_ex), .ws_excode(ws_excode), .ws_eret(ws_eret), .ws_flush(ws_flush),
    .occupancy(occupancy), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic [3:0]  we;
    logic        ex;
    logic [4:0]  excode;
    logic        eret;
    logic        mfc0;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_cnt = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          armed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: in-order queue; outputs derived from queue head and current inputs.
  always @(negedge clk) begin
    ent_t        h;
    ent_t        n;
    int          sz;
    logic        ret, e_ex, e_eret;
    logic [3:0]  e_we;
    sz  = q.size();
    ret = (sz != 0) && rf_ready && !reset;
    if (sz != 0) h = q[0];
    else h = '{default: 0};
    e_ex   = ret && h.ex;
    e_eret = ret && h.eret && !h.ex;
    e_we   = (ret && !h.ex) ? h.we : 4'b0;
    if (armed) begin
      chk("occupancy", 64'(occupancy), 64'(sz));
      chk("ws_allowin", 64'(ws_allowin), 64'(sz != DEPTH));
      chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
      chk("rf_we", 64'(rf_we), 64'(e_we));
      chk("debug_wen", 64'(debug_wb_rf_wen), 64'(e_we));
      chk("ws_ex", 64'(ws_ex), 64'(e_ex));
      chk("ws_excode", 64'(ws_excode), 64'(e_ex ? h.excode : 5'd0));
      chk("ws_eret", 64'(ws_eret), 64'(e_eret));
      chk("ws_flush", 64'(ws_flush), 64'(e_ex | e_eret));
      if (sz != 0) begin
        chk("rf_waddr", 64'(rf_waddr), 64'(h.dest));
        chk("debug_wnum", 64'(debug_wb_rf_wnum), 64'(h.dest));
        chk("rf_wdata", 64'(rf_wdata), 64'(h.mfc0 ? cp0_rdata : h.result));
        chk("debug_wdata", 64'(debug_wb_rf_wdata), 64'(h.mfc0 ? cp0_rdata : h.result));
        chk("debug_pc", 64'(debug_wb_pc), 64'(h.pc));
      end
    end
    if (reset) begin
      q.delete();
      m_cnt = '0;
    end else if (e_ex || e_eret) begin
      if (e_eret) m_cnt = m_cnt + 1;
      q.delete();
    end else begin
      if (ret) begin
        void'(q.pop_front());
        if (!h.ex) m_cnt = m_cnt + 1;
      end
      if (ms_to_ws_valid && sz != DEPTH) begin
        n = '{pc: ms_pc, result: ms_result, dest: ms_dest, we: ms_rf_we, ex: ms_ex,
              excode: ms_excode, eret: ms_eret, mfc0: ms_mfc0};
        q.push_back(n);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] dest,
                       input logic [31:0] res, input logic [3:0] we, input logic ex,
                       input logic [4:0] code, input logic eret, input logic mfc0);
    ms_to_ws_valid = v;
    ms_pc = pc; ms_dest = dest; ms_result = res; ms_rf_we = we;
    ms_ex = ex; ms_excode = code; ms_eret = eret; ms_mfc0 = mfc0;
  endtask

  initial begin
    step();
    armed = 1'b1;
    step();
    reset = 1'b0;
    chk("lit_rst_occ", 64'(occupancy), 64'd0);
    chk("lit_rst_allowin", 64'(ws_allowin), 64'd1);
    chk("lit_rst_cnt", 64'(retire_cnt), 64'd0);
    chk("lit_rst_flush", 64'(ws_flush), 64'd0);

    // Fill with rf_ready low; fifth push must be ignored
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4*i), 5'(i+1), 32'h1000 + 32'(i), 4'hF, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
    end
    chk("lit_fill_occ", 64'(occupancy), 64'd4);
    chk("lit_fill_allowin", 64'(ws_allowin), 64'd0);
    drive(1'b1, 32'h110, 5'd9, 32'h9999, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    chk("lit_fifth_ignored", 64'(occupancy), 64'd4);
    drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Drain in push order
    rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lit_drain_waddr", 64'(rf_waddr), 64'(i+1));
      chk("lit_drain_pc", 64'(debug_wb_pc), 64'(32'h100 + 32'(4*i)));
      step();
    end
    chk("lit_drain_cnt", 64'(retire_cnt), 64'd4);
    chk("lit_drain_occ", 64'(occupancy), 64'd0);
    rf_ready = 1'b0;

    // Streaming from a clean reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    rf_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h300 + 32'(4*i), 5'((i % 31) + 1), 32'h3000 + 32'(i), 4'hF, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
    end
    chk("lit_stream_cnt", 64'(retire_cnt), 64'd19);
    chk("lit_stream_occ", 64'(occupancy), 64'd1);
    drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    rf_ready = 1'b0;

    // Exception head with two younger entries and a simultaneous push
    drive(1'b1, 32'h200, 5'd3, 32'h2000, 4'hF, 1'b1, 5'h04, 1'b0, 1'b0); step();
    drive(1'b1, 32'h204, 5'd4, 32'h2004, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h208, 5'd5, 32'h2008, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h20C, 5'd6, 32'h200C, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0);
    rf_ready = 1'b1;
    #1;
    chk("lit_exc_ws_ex", 64'(ws_ex), 64'd1);
    chk("lit_exc_code", 64'(ws_excode), 64'h04);
    chk("lit_exc_rf_we", 64'(rf_we), 64'd0);
    chk("lit_exc_flush", 64'(ws_flush), 64'd1);
    step();
    chk("lit_exc_occ", 64'(occupancy), 64'd0);
    chk("lit_exc_cnt", 64'(retire_cnt), 64'd20);
    drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    rf_ready = 1'b0;

    // MFC0 then ERET, with a younger entry that the ERET must flush
    drive(1'b1, 32'h400, 5'd7, 32'h1111, 4'hF, 1'b0, 5'd0, 1'b0, 1'b1); step();
    drive(1'b1, 32'h404, 5'd0, 32'h0,    4'h0, 1'b0, 5'd0, 1'b1, 1'b0); step();
    drive(1'b1, 32'h408, 5'd8, 32'h2222, 4'hF, 1'b0, 5'd0, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    cp0_rdata = 32'hDEADBEEF;
    rf_ready = 1'b1;
    #1;
    chk("lit_mfc0_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    chk("lit_mfc0_waddr", 64'(rf_waddr), 64'd7);
    chk("lit_mfc0_we", 64'(rf_we), 64'hF);
    step();
    chk("lit_mfc0_cnt", 64'(retire_cnt), 64'd21);
    #1;
    chk("lit_eret", 64'(ws_eret), 64'd1);
    chk("lit_eret_flush", 64'(ws_flush), 64'd1);
    chk("lit_eret_noex", 64'(ws_ex), 64'd0);
    step();
    chk("lit_eret_occ", 64'(occupancy), 64'd0);
    chk("lit_eret_cnt", 64'(retire_cnt), 64'd22);
    rf_ready = 1'b0;

    // Reset with three entries buffered
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(4*i), 5'(10+i), 32'h5000 + 32'(i), 4'hF, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("lit_pre_rst_occ", 64'(occupancy), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("lit_mid_rst_occ", 64'(occupancy), 64'd0);
    chk("lit_mid_rst_cnt", 64'(retire_cnt), 64'd0);
    chk("lit_mid_rst_allowin", 64'(ws_allowin), 64'd1);
    rf_ready = 1'b1;
    #1;
    chk("lit_mid_rst_rf_we", 64'(rf_we), 64'd0);
    step();

    // Mixed traffic checked by the model only
    for (int i = 0; i < 40; i++) begin
      drive((i % 3) != 0, 32'h600 + 32'(4*i), 5'(i % 32), 32'(i * 32'h11),
            (i % 5 == 0) ? 4'h3 : 4'hF, i == 23, 5'(i), i == 31, (i % 7) == 0);
      cp0_rdata = 32'hC000_0000 + 32'(i);
      rf_ready  = (i % 4) != 1;
      step();
    end
    drive(1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    rf_ready = 1'b1;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
